boid_frame_scanner: RTL and testbench

//   Reader side of the boid display memory. Generates 640x480@60 raster timing,

---
 rtl/boid_frame_scanner.sv | 125 ++++++++++++
 tb/tb_boid_frame_scanner.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/boid_frame_scanner.sv
// Raster scanner for the 1-bit boid framebuffer: 640x480@60 timing, sequential
// framebuffer addressing, one-tick colour/sync pipeline and an end-of-active pulse.
module boid_frame_scanner #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          ADDR_WIDTH = 19,
  parameter logic [11:0] BOID_RGB   = 12'hFFF,
  parameter logic [11:0] BG_RGB     = 12'h000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pix_en,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  read_data,
  output logic                  hSync,
  output logic                  vSync,
  output logic [3:0]            VGA_R,
  output logic [3:0]            VGA_G,
  output logic [3:0]            VGA_B,
  output logic                  screen_end_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT      = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] H_ACT_LAST = H_W'(H_ACTIVE - 1);
  localparam logic [H_W-1:0] HS_BEG     = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END     = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT      = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_ACT_LAST = V_W'(V_ACTIVE - 1);
  localparam logic [V_W-1:0] VS_BEG     = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END     = V_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(H_ACTIVE * V_ACTIVE - 1);

  logic [H_W-1:0]        h_q, h_d;
  logic [V_W-1:0]        v_q, v_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [11:0]           rgb_p1_q, rgb_p1_d;
  logic                  hs_p1_q, hs_p1_d;
  logic                  vs_p1_q, vs_p1_d;
  logic                  vld_p1_q, vld_p1_d;
  logic                  end_p1_q, end_p1_d;
  logic                  active;

  // Saturating step: the last visible pixel holds the address through blanking.
  function automatic logic [ADDR_WIDTH-1:0] addr_step(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_MAX) ? a : a + ADDR_WIDTH'(1);
  endfunction

  always_comb begin
    h_d      = h_q;
    v_d      = v_q;
    addr_d   = addr_q;
    rgb_p1_d = rgb_p1_q;
    hs_p1_d  = hs_p1_q;
    vs_p1_d  = vs_p1_q;
    vld_p1_d = vld_p1_q;
    end_p1_d = 1'b0;
    active   = (h_q < H_ACT) && (v_q < V_ACT);

    if (pix_en) begin
      // Stage p0 -> p1: colour and sync for the current (h,v) register together.
      rgb_p1_d = active ? (read_data ? BOID_RGB : BG_RGB) : 12'h000;
      hs_p1_d  = !((h_q >= HS_BEG) && (h_q < HS_END));
      vs_p1_d  = !((v_q >= VS_BEG) && (v_q < VS_END));
      vld_p1_d = 1'b1;
      end_p1_d = (h_q == H_ACT_LAST) && (v_q == V_ACT_LAST);

      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + V_W'(1);
      end else begin
        h_d = h_q + H_W'(1);
      end

      if ((h_q == H_LAST) && (v_q == V_LAST))
        addr_d = '0;
      else if (active)
        addr_d = addr_step(addr_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_q      <= '0;
      v_q      <= '0;
      addr_q   <= '0;
      rgb_p1_q <= 12'h000;
      hs_p1_q  <= 1'b1;
      vs_p1_q  <= 1'b1;
      vld_p1_q <= 1'b0;
      end_p1_q <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      addr_q   <= addr_d;
      rgb_p1_q <= rgb_p1_d;
      hs_p1_q  <= hs_p1_d;
      vs_p1_q  <= vs_p1_d;
      vld_p1_q <= vld_p1_d;
      end_p1_q <= end_p1_d;
    end
  end

  assign read_addr      = addr_q;
  assign hSync          = hs_p1_q;
  assign vSync          = vs_p1_q;
  assign VGA_R          = vld_p1_q ? rgb_p1_q[11:8] : 4'h0;
  assign VGA_G          = vld_p1_q ? rgb_p1_q[7:4]  : 4'h0;
  assign VGA_B          = vld_p1_q ? rgb_p1_q[3:0]  : 4'h0;
  assign screen_end_out = end_p1_q;

endmodule

// File: tb/tb_boid_frame_scanner.sv
// Scoreboard bench for boid_frame_scanner on a reduced raster (24x17 total,
// 16x12 visible) so several whole frames fit in a short run.
module tb_boid_frame_scanner;

  localparam int HA = 16, HF = 2, HS = 4, HB = 2;
  localparam int VA = 12, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int AW = 19;
  localparam int PX = 10, PY = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          pix_en;
  logic [AW-1:0] read_addr;
  logic          read_data;
  logic          hSync, vSync;
  logic [3:0]    VGA_R, VGA_G, VGA_B;
  logic          screen_end_out;

  always #5 clock = ~clock;

  boid_frame_scanner #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .ADDR_WIDTH(AW), .BOID_RGB(12'hFFF), .BG_RGB(12'h000)
  ) dut (
    .clock(clock), .reset(reset), .pix_en(pix_en),
    .read_addr(read_addr), .read_data(read_data),
    .hSync(hSync), .vSync(vSync),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .screen_end_out(screen_end_out)
  );

  // One-clock-latency framebuffer with a single boid pixel set.
  always @(posedge clock) read_data <= (read_addr == AW'(PY * HA + PX));

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        se;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int checks = 0, failures = 0;
  int mh = 0, mv = 0;
  int pulses = 0, gap = 0, first_win = 1, hs_low = 0, vs_low = 0, boid_px = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (h=%0d v=%0d t=%0t)", tag, got, exp, mh, mv, $time);
    end
  endtask

  function automatic int exp_addr(input int h, input int v);
    if (h < HA && v < VA) return v * HA + h;
    if (v < VA - 1)       return (v + 1) * HA;
    return HA * VA - 1;
  endfunction

  function automatic exp_t model_out(input int h, input int v);
    exp_t e;
    e.rgb = (h < HA && v < VA && h == PX && v == PY) ? 12'hFFF : 12'h000;
    e.hs  = !(h >= HA + HF && h < HA + HF + HS);
    e.vs  = !(v >= VA + VF && v < VA + VF + VS);
    e.se  = (h == HA - 1) && (v == VA - 1);
    return e;
  endfunction

  task automatic model_adv();
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
  endtask

  function automatic logic [11:0] dut_rgb();
    return {VGA_R, VGA_G, VGA_B};
  endfunction

  task automatic step(input bit en);
    exp_t e;
    chk_eq("read_addr", 32'(read_addr), exp_addr(mh, mv));
    pix_en = en;
    if (en) begin
      q.push_back(model_out(mh, mv));
      model_adv();
    end
    @(posedge clock);
    #1;
    pix_en = 1'b0;
    if (en) begin
      e = q.pop_front();
      chk_eq("rgb", 32'(dut_rgb()), 32'(e.rgb));
      chk_eq("hsync", 32'(hSync), 32'(e.hs));
      chk_eq("vsync", 32'(vSync), 32'(e.vs));
      chk_eq("screen_end", 32'(screen_end_out), 32'(e.se));
      last = e;
      gap++;
      if (!hSync) hs_low++;
      if (!vSync) vs_low++;
      if (dut_rgb() == 12'hFFF) boid_px++;
      if (screen_end_out) begin
        pulses++;
        chk_eq("frame_gap", gap, first_win ? (VA - 1) * HT + HA : FRAME);
        chk_eq("boid_pixels", boid_px, 1);
        if (!first_win) begin
          chk_eq("hsync_low_ticks", hs_low, HS * VT);
          chk_eq("vsync_low_ticks", vs_low, VS * HT);
        end
        first_win = 0; gap = 0; hs_low = 0; vs_low = 0; boid_px = 0;
      end
    end else begin
      chk_eq("screen_end_idle", 32'(screen_end_out), 0);
      chk_eq("rgb_hold", 32'(dut_rgb()), 32'(last.rgb));
      chk_eq("hsync_hold", 32'(hSync), 32'(last.hs));
      chk_eq("vsync_hold", 32'(vSync), 32'(last.vs));
    end
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0);
      step(1'b0);
      step(1'b0);
      step(1'b1);
    end
  endtask

  task automatic do_reset(input bit en);
    reset  = 1'b1;
    pix_en = en;
    @(posedge clock);
    #1;
    reset  = 1'b0;
    pix_en = 1'b0;
    mh = 0;
    mv = 0;
    q.delete();
    last = '{12'h000, 1'b1, 1'b1, 1'b0};
    chk_eq("rst_rgb", 32'(dut_rgb()), 0);
    chk_eq("rst_hsync", 32'(hSync), 1);
    chk_eq("rst_vsync", 32'(vSync), 1);
    chk_eq("rst_screen_end", 32'(screen_end_out), 0);
    chk_eq("rst_read_addr", 32'(read_addr), 0);
    gap = 0; first_win = 1; hs_low = 0; vs_low = 0; boid_px = 0;
  endtask

  initial begin
    reset  = 1'b1;
    pix_en = 1'b0;
    #1;
    do_reset(1'b0);
    run_ticks(2 * FRAME + 3 * HT + 5);
    // Stall mid-line at (5,3) of the third frame.
    repeat (50) step(1'b0);
    run_ticks(3 * HT + 3);
    // Mid-frame reset with pix_en also high; reset must win.
    do_reset(1'b1);
    run_ticks(FRAME + 10);
    chk_eq("pulse_count", pulses, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
